// File: rtl/rotation_tracker.sv
// rotation_tracker: per-channel rotation-direction tracker for the CORDIC angle path.
//
// Takes a time-multiplexed stream of wrapped angle samples. For each channel it
// computes the shortest-path signed delta modulo MODULUS, then derives a
// hysteretic direction and a saturating direction-lock flag. Each accepted
// sample produces one registered result in the following cycle.
//
// Ports:
//   clock    - clock; all state updates on the rising edge
//   reset    - synchronous, active-low reset
//   i_flush  - synchronous clear of all channel state and outputs (o_err kept)
//   i_valid  - sample strobe
//   i_ch     - channel index of the sample
//   i_angle  - angle sample, legal range 0..MODULUS-1
//   o_valid  - result strobe, one cycle after an accepted sample
//   o_ch     - channel of the result
//   o_dir    - 1 = increasing angle, 0 = clockwise
//   o_delta  - wrapped delta in [-MODULUS/2, MODULUS/2-1]
//   o_lock   - direction stable for LOCK_CNT consecutive moves
//   o_err    - sticky flag for an out-of-range angle or channel; cleared by reset only
module rotation_tracker #(
  parameter int unsigned W        = 16,
  parameter int unsigned MODULUS  = 360,
  parameter int unsigned N_CH     = 4,
  parameter int unsigned DEADBAND = 0,
  parameter int unsigned LOCK_CNT = 8,
  localparam int unsigned CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [CW-1:0]       i_ch,
  input  logic [W-1:0]        i_angle,
  output logic                o_valid,
  output logic [CW-1:0]       o_ch,
  output logic                o_dir,
  output logic signed [W:0]   o_delta,
  output logic                o_lock,
  output logic                o_err
);

  localparam int unsigned CntW = $clog2(LOCK_CNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(LOCK_CNT);

  // Delta arithmetic uses W+2 bits so that MODULUS = 2^W still fits as a
  // positive signed constant; the wrapped result always fits in W+1 bits.
  localparam logic signed [W+1:0] ModS  = (W+2)'(MODULUS);
  localparam logic signed [W+1:0] HalfS = (W+2)'(MODULUS / 2);
  localparam logic signed [W+1:0] DbS   = (W+2)'(DEADBAND);

  // Per-channel state
  logic [W-1:0]    prev_q [N_CH];
  logic            seen_q [N_CH];
  logic            dir_q  [N_CH];
  logic [CntW-1:0] cnt_q  [N_CH];

  logic            ch_ok, angle_ok, accept, reject;
  logic [CW-1:0]   ch_idx;
  logic [W-1:0]    prev_sel;
  logic            seen_sel, dir_sel;
  logic [CntW-1:0] cnt_sel;

  logic signed [W+1:0] diff, wrapped;
  logic                move_up, move_dn;
  logic                dir_new, lock_new;
  logic [CntW-1:0]     cnt_new;
  logic signed [W:0]   delta_new;

  assign ch_ok    = ({1'b0, i_ch} < (CW+1)'(N_CH));
  assign angle_ok = ({1'b0, i_angle} < (W+1)'(MODULUS));
  assign accept   = i_valid && ch_ok && angle_ok;
  assign reject   = i_valid && !(ch_ok && angle_ok);

  // Keep the state read in range even when the sample is going to be dropped.
  assign ch_idx   = ch_ok ? i_ch : '0;
  assign prev_sel = prev_q[ch_idx];
  assign seen_sel = seen_q[ch_idx];
  assign dir_sel  = dir_q[ch_idx];
  assign cnt_sel  = cnt_q[ch_idx];

  always_comb begin
    diff      = $signed({2'b00, i_angle}) - $signed({2'b00, prev_sel});
    wrapped   = diff;
    move_up   = 1'b0;
    move_dn   = 1'b0;
    dir_new   = dir_sel;
    cnt_new   = cnt_sel;
    lock_new  = 1'b0;
    delta_new = '0;

    // A half turn (diff = +MODULUS/2) lands on -MODULUS/2, i.e. clockwise.
    if (diff >= HalfS) begin
      wrapped = diff - ModS;
    end else if (diff < -HalfS) begin
      wrapped = diff + ModS;
    end

    if (seen_sel) begin
      move_up   = (wrapped > DbS);
      move_dn   = (wrapped < -DbS);
      delta_new = wrapped[W:0];
      if (move_up || move_dn) begin
        dir_new = move_up;
        if (dir_new != dir_sel) begin
          cnt_new = CntW'(1);
        end else if (cnt_sel < CntMax) begin
          cnt_new = cnt_sel + CntW'(1);
        end
      end
      lock_new = (cnt_new >= CntMax);
    end
  end

  // Channel state and result registers; flush clears the same set as reset.
  always_ff @(posedge clock) begin
    if (!reset || i_flush) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        prev_q[i] <= '0;
        seen_q[i] <= 1'b0;
        dir_q[i]  <= 1'b0;
        cnt_q[i]  <= '0;
      end
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_dir   <= 1'b0;
      o_delta <= '0;
      o_lock  <= 1'b0;
    end else begin
      o_valid <= accept;
      if (accept) begin
        prev_q[ch_idx] <= i_angle;
        seen_q[ch_idx] <= 1'b1;
        dir_q[ch_idx]  <= dir_new;
        cnt_q[ch_idx]  <= cnt_new;
        o_ch           <= i_ch;
        o_dir          <= dir_new;
        o_delta        <= delta_new;
        o_lock         <= lock_new;
      end
    end
  end

  // Sticky error survives flush; a sample dropped by flush does not set it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      o_err <= 1'b0;
    end else if (!i_flush && reject) begin
      o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rotation_tracker.sv
// Self-checking bench for rotation_tracker: directed scenarios followed by a
// randomized stream, compared cycle by cycle against a behavioural model.
module tb_rotation_tracker;

  localparam int W    = 16;
  localparam int MOD  = 360;
  localparam int NCH  = 3;   // leaves i_ch = 3 representable as an illegal channel
  localparam int DB   = 2;
  localparam int LOCK = 8;
  localparam int CW   = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                i_flush = 1'b0;
  logic                i_valid = 1'b0;
  logic [CW-1:0]       i_ch = '0;
  logic [W-1:0]        i_angle = '0;
  logic                o_valid;
  logic [CW-1:0]       o_ch;
  logic                o_dir;
  logic signed [W:0]   o_delta;
  logic                o_lock;
  logic                o_err;

  rotation_tracker #(
    .W        (W),
    .MODULUS  (MOD),
    .N_CH     (NCH),
    .DEADBAND (DB),
    .LOCK_CNT (LOCK)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_ch    (i_ch),
    .i_angle (i_angle),
    .o_valid (o_valid),
    .o_ch    (o_ch),
    .o_dir   (o_dir),
    .o_delta (o_delta),
    .o_lock  (o_lock),
    .o_err   (o_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_prev [NCH];
  int m_cnt  [NCH];
  int m_seen [NCH];
  int m_dir  [NCH];
  int e_valid, e_ch, e_dir, e_delta, e_lock, e_err;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear(input bit clr_err);
    for (int i = 0; i < NCH; i++) begin
      m_prev[i] = 0; m_cnt[i] = 0; m_seen[i] = 0; m_dir[i] = 0;
    end
    e_valid = 0; e_ch = 0; e_dir = 0; e_delta = 0; e_lock = 0;
    if (clr_err) e_err = 0;
  endfunction

  // Shortest signed path from a to b on a circle of MOD units, in [-MOD/2, MOD/2-1].
  function automatic int circ_delta(input int a, input int b);
    int d;
    d = (b - a) % MOD;
    if (d < 0) d += MOD;
    if (d >= MOD / 2) d -= MOD;
    return d;
  endfunction

  function automatic void model_step(input bit v, input bit fl, input int ch, input int ang);
    int d;
    if (fl) begin
      model_clear(1'b0);
    end else if (v && ch < NCH && ang < MOD) begin
      e_valid = 1;
      e_ch    = ch;
      if (m_seen[ch] == 0) begin
        m_seen[ch] = 1;
        e_delta = 0;
        e_lock  = 0;
      end else begin
        d = circ_delta(m_prev[ch], ang);
        if (d > DB || d < -DB) begin
          if ((d > DB) == (m_dir[ch] == 1)) m_cnt[ch] = (m_cnt[ch] < LOCK) ? m_cnt[ch] + 1 : LOCK;
          else m_cnt[ch] = 1;
          m_dir[ch] = (d > DB) ? 1 : 0;
        end
        e_delta = d;
        e_lock  = (m_cnt[ch] >= LOCK) ? 1 : 0;
      end
      e_dir = m_dir[ch];
      m_prev[ch] = ang;
    end else begin
      e_valid = 0;
      if (v) e_err = 1;
    end
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid"}, int'(o_valid), e_valid);
    check_eq({tag, ".ch"},    int'(o_ch),    e_ch);
    check_eq({tag, ".dir"},   int'(o_dir),   e_dir);
    check_eq({tag, ".delta"}, int'(o_delta), e_delta);
    check_eq({tag, ".lock"},  int'(o_lock),  e_lock);
    check_eq({tag, ".err"},   int'(o_err),   e_err);
  endtask

  // Apply one cycle of stimulus, then compare after the edge.
  task automatic step(input string tag, input bit v, input bit fl, input int ch, input int ang);
    i_valid = v;
    i_flush = fl;
    i_ch    = CW'(ch);
    i_angle = W'(ang);
    @(posedge clock);
    #1;
    model_step(v, fl, ch, ang);
    compare_all(tag);
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b0;
    i_valid = 1'b0;
    i_flush = 1'b0;
    @(posedge clock);
    #1;
    model_clear(1'b1);
    compare_all(tag);
    reset = 1'b1;
  endtask

  int walk  [NCH];
  int trend [NCH];

  initial begin
    model_clear(1'b1);
    do_reset("reset");

    // Single-channel ramp: lock on the 9th result
    for (int k = 1; k <= 10; k++) step("ramp", 1, 0, 0, k * 10);
    step("idle", 0, 0, 0, 0);

    // Wrap-around on ch1
    step("wrap0", 1, 0, 1, 350);
    step("wrap1", 1, 0, 1, 5);
    step("wrap2", 1, 0, 1, 355);

    // Half turn and dead band on ch2
    step("half0", 1, 0, 2, 0);
    step("half1", 1, 0, 2, 180);
    step("db0",   1, 0, 2, 100);
    step("db1",   1, 0, 2, 102);

    // Interleaved channels
    for (int k = 1; k <= 10; k++) begin
      step("ilv0", 1, 0, 0, (100 + 5 * k) % MOD);
      step("ilv2", 1, 0, 2, (102 - 5 * k + MOD) % MOD);
    end

    // Errors: bad angle, bad channel, then ch0 continues unaffected
    step("err_ang", 1, 0, 0, 360);
    step("err_ch",  1, 0, 3, 10);
    step("err_ok",  1, 0, 0, 160);
    step("err_fl",  0, 1, 0, 0);
    step("err_hold", 0, 0, 0, 0);
    do_reset("err_rst");

    // Flush mid-stream after lock
    for (int k = 0; k <= 9; k++) step("lock", 1, 0, 0, 200 + 3 * k);
    step("flush", 1, 1, 0, 300);
    step("post_fl", 1, 0, 0, 50);
    step("post_fl2", 1, 0, 0, 40);

    // Randomized stream
    for (int i = 0; i < NCH; i++) begin
      walk[i]  = $urandom_range(0, MOD - 1);
      trend[i] = $urandom_range(0, 1);
    end
    for (int n = 0; n < 3000; n++) begin
      int ch, ang, r;
      bit v, fl;
      r  = $urandom_range(0, 999);
      if (r < 5) begin
        do_reset("rnd_rst");
        continue;
      end
      v  = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 99) < 2);
      ch = $urandom_range(0, 3);
      if (ch < NCH) begin
        if ($urandom_range(0, 99) < 5) trend[ch] = 1 - trend[ch];
        if ($urandom_range(0, 99) < 4) begin
          walk[ch] = $urandom_range(0, MOD - 1);
        end else if (trend[ch] == 1) begin
          walk[ch] = (walk[ch] + $urandom_range(0, 15)) % MOD;
        end else begin
          walk[ch] = (walk[ch] + MOD - $urandom_range(0, 15)) % MOD;
        end
        ang = walk[ch];
      end else begin
        ang = $urandom_range(0, MOD - 1);
      end
      if ($urandom_range(0, 99) < 3) ang = $urandom_range(MOD, MOD + 100);
      step("rnd", v, fl, ch, ang);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rotation_tracker.md
# rotation_tracker

Per-channel rotation-direction tracker for the CORDIC angle path. It accepts a time-multiplexed stream of wrapped angle samples from up to N_CH channels and computes each channel's shortest-path signed delta modulo MODULUS. From that delta it derives a hysteretic rotation direction and a saturating direction-lock indicator. One registered result is produced per accepted sample.

## Interface
- W, 16: angle sample width (unsigned).
- MODULUS, 360: full-turn value; legal angles are 0..MODULUS-1; must be even, ≤ 2^W.
- N_CH, 4: number of channels; ≥ 1.
- DEADBAND, 0: |delta| ≤ DEADBAND holds the previous direction.
- LOCK_CNT, 8: number of consecutive same-direction moves required to assert lock; ≥ 1.
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-low.
- i_flush  in  1  synchronous clear of all channel state; same effect as reset except on o_err.
- i_valid  in  1  sample strobe.
- i_ch  in  max(1,clog2(N_CH))  channel index of the sample.
- i_angle  in  W  angle sample.
- o_valid  out  1  result strobe, one cycle after an accepted sample.
- o_ch  out  max(1,clog2(N_CH))  channel of the result.
- o_dir  out  1  1 = trigonometric (increasing angle), 0 = clockwise.
- o_delta  out  W+1 signed  wrapped delta in [-MODULUS/2, MODULUS/2-1].
- o_lock  out  1  direction stable for LOCK_CNT consecutive moves.
- o_err  out  1  sticky flag: an out-of-range angle or channel was seen.

## Operation
- Per-channel state:
  - prev angle (W bits);
  - seen flag;
  - dir;
  - lock counter, saturating at LOCK_CNT.
- Accept rule: sample accepted when i_valid=1, i_ch<N_CH and i_angle<MODULUS.
- Reject rule: otherwise, when i_valid=1, the sample is dropped. No state change, o_valid=0, o_err set to 1. o_err is cleared only by reset.
- First accepted sample of a channel (seen=0):
  - store the angle and set seen=1;
  - o_delta=0, o_dir = the stored dir, o_lock=0, counter unchanged.
- Later samples:
  - d = cur − prev, computed in W+1 bits;
  - if d ≥ MODULUS/2 then d −= MODULUS; if d < −MODULUS/2 then d += MODULUS.
- Direction from d:
  - d > DEADBAND: new dir = 1.
  - d < −DEADBAND: new dir = 0.
  - otherwise (including d = 0): dir held.
- Half-turn case: d = MODULUS/2 before wrapping wraps to −MODULUS/2 and is treated as clockwise.
- Lock counter:
  - Moving sample (|d| > DEADBAND) with new dir = old dir: counter increments, saturating at LOCK_CNT.
  - Moving sample with a changed dir: counter = 1.
  - Dead-band sample: counter unchanged.
- o_lock = (counter after update ≥ LOCK_CNT).
- prev is always updated to cur on an accepted sample, including dead-band samples.
- Reset or i_flush:
  - all channels: seen=0, dir=0, counter=0, prev=0;
  - outputs: o_valid=0, o_ch=0, o_dir=0, o_delta=0, o_lock=0;
  - o_err=0 on reset only.
- Simultaneous i_flush and i_valid: flush wins and the sample is dropped; o_err is not set by that sample.
- Reset or flush mid-stream: the next sample on each channel is treated as a first sample.

## Timing
- Latency: exactly 1 cycle from accepted sample to o_valid.
- All outputs are registered. o_ch/o_dir/o_delta/o_lock hold their last values while o_valid=0.
- Throughput: one sample per cycle, with no back-pressure.
- Back-to-back samples on the same channel in consecutive cycles must use the just-written state. The read-modify-write completes in one cycle, so no hazard is permitted.
- o_err asserts in the cycle after the offending sample.

## Test plan
- Single-channel ramp:
  - reset, then ch0 angles 10, 20, 30, …, 100 on consecutive cycles;
  - expected: first o_delta=0, o_dir=0; then o_delta=+10 and o_dir=1 each result;
  - o_lock rises on the 9th result (8th move) and stays 1.
- Wrap-around:
  - ch1: 350 → 5 gives o_delta=+15, o_dir=1;
  - then 5 → 355 gives o_delta=−10, o_dir=0, lock counter = 1, o_lock=0.
- Half-turn and dead band:
  - 0 → 180 gives o_delta=−180, o_dir=0;
  - with DEADBAND=2, 100 → 102 leaves dir and counter unchanged, o_delta=+2.
- Interleaved channels:
  - ch0/ch2 alternate every cycle, ch0 increasing by 5 and ch2 decreasing by 5;
  - expected: per-channel o_dir 1/0 and o_ch matching the inputs, with no cross-talk.
- Errors:
  - i_angle=360 on ch0, then i_ch=N_CH (if representable);
  - expected: o_valid=0 for both, o_err=1 sticky through a flush, cleared only by reset; ch0 state unchanged.
- Flush mid-stream:
  - lock ch0, then pulse i_flush together with i_valid;
  - expected: sample dropped, next cycle all outputs 0;
  - the next ch0 sample yields o_delta=0, o_lock=0.
